// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one external W-bit adder among NREQ requesters.
// Operands are registered out to the adder, and the sum is captured one cycle later into a tagged response.
module adder_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 6,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [W-1:0]        add_a,
  output logic [W-1:0]        add_b,
  input  logic [W:0]          add_s,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [W:0]          rsp_sum,
  output logic                busy,
  output logic [CNTW-1:0]     op_count
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] gid_p0;
  logic           accept_slot;
  logic           take;

  // First valid requester at or after p, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  p);
    logic [IDW-1:0] g;
    logic           found;
    int             idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(p) + i) % NREQ;
      if (!found && v[idx]) begin
        g     = IDW'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g);
    return (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);
  endfunction

  assign grant = rr_pick(req_valid, ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = take ? EVAL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept_slot = (state == IDLE) || ((state == RESP) && rsp_ready);
    take        = accept_slot && (|req_valid);
    busy        = (state != IDLE);
    req_ready   = '0;
    if (rst_n && take) req_ready[grant] = 1'b1;
  end

  // Stage p0: latch the granted operands toward the adder and advance the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a  <= '0;
      add_b  <= '0;
      gid_p0 <= '0;
      ptr    <= '0;
    end else if (take) begin
      add_a  <= req_a[int'(grant)*W +: W];
      add_b  <= req_b[int'(grant)*W +: W];
      gid_p0 <= grant;
      ptr    <= next_ptr(grant);
    end
  end

  // Stage p1: capture the adder result into the response channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      op_count  <= '0;
    end else begin
      if (state == EVAL) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gid_p0;
        rsp_sum   <= add_s;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a behavioural adder closing the loop.
module tb_adder_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 6;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W:0]        add_s;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  adder_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_a [4];
    int exp_b [4];
    int exp_s [4];
    int id;
    exp_a = '{1, 11, 21, 31};
    exp_b = '{2, 50, 40, 33};
    exp_s = '{3, 61, 61, 64};

    rst_n = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_op_count",  32'(op_count), 0);
    chk("rst_add_a",     32'(add_a), 0);

    // T2: single request from requester 1
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0010; set_ops(1, 45, 30); #1;
    chk("t2_req_ready", 32'(req_ready), 2);
    chk("t2_idle_busy", 32'(busy), 0);
    @(negedge clk);
    req_valid = 4'b0000; #1;
    chk("t2_add_a", 32'(add_a), 45);
    chk("t2_add_b", 32'(add_b), 30);
    chk("t2_eval_busy", 32'(busy), 1);
    chk("t2_eval_rsp_valid", 32'(rsp_valid), 0);
    chk("t2_eval_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("t2_rsp_valid", 32'(rsp_valid), 1);
    chk("t2_rsp_id",    32'(rsp_id), 1);
    chk("t2_rsp_sum",   32'(rsp_sum), 75);

    // T4: backpressure with a pending request from requester 0 (pointer now 2)
    req_valid = 4'b0001; set_ops(0, 63, 63);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_rsp_valid", 32'(rsp_valid), 1);
      chk("t4_rsp_id",    32'(rsp_id), 1);
      chk("t4_rsp_sum",   32'(rsp_sum), 75);
      chk("t4_req_ready", 32'(req_ready), 0);
      chk("t4_op_count",  32'(op_count), 0);
      @(negedge clk);
    end
    // T6: release; search from pointer 2 skips to requester 0
    rsp_ready = 1'b1; #1;
    chk("t6_skip_grant", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b0; #1;
    chk("t4_op_count_inc", 32'(op_count), 1);
    chk("t4_rsp_cleared",  32'(rsp_valid), 0);
    chk("t5_add_a_63",     32'(add_a), 63);
    @(negedge clk);
    chk("t5_sum_126", 32'(rsp_sum), 126);
    chk("t5_id_0",    32'(rsp_id), 0);
    // Pointer should now be 1: with all valid, requester 1 wins
    set_ops(1, 63, 1); set_ops(2, 0, 0);
    req_valid = 4'b1111; rsp_ready = 1'b1; #1;
    chk("t6_next_ptr_grant", 32'(req_ready), 2);
    @(negedge clk);
    req_valid = 4'b0000; #1;
    chk("t5_op_count_2", 32'(op_count), 2);
    @(negedge clk);
    chk("t5_sum_64", 32'(rsp_sum), 64);
    chk("t5_id_1",   32'(rsp_id), 1);
    req_valid = 4'b0100; #1;
    chk("t5_grant_2", 32'(req_ready), 4);
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b0;
    @(negedge clk);
    chk("t5_sum_0",     32'(rsp_sum), 0);
    chk("t5_id_2",      32'(rsp_id), 2);
    chk("t5_rsp_valid", 32'(rsp_valid), 1);
    chk("t5_op_count_3", 32'(op_count), 3);

    // T1: asynchronous reset in the middle of RESP
    rst_n = 1'b0; req_valid = 4'b1111; #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_busy",      32'(busy), 0);
    chk("t1_op_count",  32'(op_count), 0);
    chk("t1_req_ready", 32'(req_ready), 0);
    chk("t1_rsp_sum",   32'(rsp_sum), 0);
    chk("t1_add_a",     32'(add_a), 0);

    // T3: fairness with all requesters valid, consumer always ready
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_ops(i, exp_a[i], exp_b[i]);
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      id = n % NREQ;
      #1;
      chk("t3_grant", 32'(req_ready), 32'(1) << id);
      @(negedge clk); #1;
      chk("t3_eval_req_ready", 32'(req_ready), 0);
      chk("t3_eval_rsp_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("t3_rsp_valid", 32'(rsp_valid), 1);
      chk("t3_rsp_id",    32'(rsp_id), 32'(id));
      chk("t3_rsp_sum",   32'(rsp_sum), 32'(exp_s[id]));
      chk("t3_op_count",  32'(op_count), 32'(n));
    end
    req_valid = 4'b0000;
    @(negedge clk); #1;
    chk("t3_op_count_6", 32'(op_count), 6);
    chk("t3_idle_busy",  32'(busy), 0);
    chk("t3_rsp_done",   32'(rsp_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
